// File: rtl/fpu_pkg.sv
// Shared definitions for the sequential FPU normalizer: state encoding,
// requester tags and the exponent all-ones helper.
package fpu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic TAG_ADD = 1'b0;
    localparam logic TAG_MUL = 1'b1;

    // Width-generic all-ones pattern; a 32-bit width wraps to all-ones as well.
    function automatic logic [31:0] exp_all_ones(input int unsigned width);
        return (32'd1 << width) - 32'd1;
    endfunction

endpackage

// File: rtl/fpu_norm_sequencer_if.sv
// Request/result bundle between the FPU datapath requesters and the normalizer.
interface fpu_norm_sequencer_if #(
    parameter int Mantissa_Size = 23,
    parameter int Exponent_Size = 8
);
    logic [1:0]               req_valid;
    logic [1:0]               req_ready;
    logic [Mantissa_Size:0]   req_mantissa0;
    logic [Mantissa_Size:0]   req_mantissa1;
    logic [Exponent_Size-1:0] req_exponent0;
    logic [Exponent_Size-1:0] req_exponent1;
    logic                     out_valid;
    logic                     out_ready;
    logic                     out_tag;
    logic [Mantissa_Size-1:0] out_mantissa;
    logic [Exponent_Size-1:0] out_exponent;
    logic                     out_zero;
    logic                     out_overflow;
    logic                     out_underflow;
    logic                     busy;

    modport master (
        output req_valid, req_mantissa0, req_mantissa1, req_exponent0, req_exponent1, out_ready,
        input  req_ready, out_valid, out_tag, out_mantissa, out_exponent,
               out_zero, out_overflow, out_underflow, busy
    );

    modport slave (
        input  req_valid, req_mantissa0, req_mantissa1, req_exponent0, req_exponent1, out_ready,
        output req_ready, out_valid, out_tag, out_mantissa, out_exponent,
               out_zero, out_overflow, out_underflow, busy
    );
endinterface

// File: rtl/fpu_rr_arbiter2.sv
// Two-way round-robin arbiter: the pointer names the favoured requester and
// moves to the other one after every grant.
module fpu_rr_arbiter2
    import fpu_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [1:0] req,
    output logic [1:0] grant,
    output logic       grant_idx
);
    logic rr_ptr;

    always_comb begin
        grant     = 2'b00;
        grant_idx = rr_ptr;
        if (enable) begin
            if (req[rr_ptr]) begin
                grant[rr_ptr] = 1'b1;
                grant_idx     = rr_ptr;
            end else if (req[~rr_ptr]) begin
                grant[~rr_ptr] = 1'b1;
                grant_idx      = ~rr_ptr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr <= TAG_ADD;
        end else if (|grant) begin
            rr_ptr <= ~grant_idx;
        end
    end

endmodule

// File: rtl/fpu_norm_sequencer.sv
// Shared sequential normalizer: accepts one raw {mantissa, exponent} pair from
// two requesters and normalizes it one bit position per clock.
module fpu_norm_sequencer
    import fpu_pkg::*;
#(
    parameter int Mantissa_Size = 23,
    parameter int Exponent_Size = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fpu_norm_sequencer_if.slave  bus
);
    localparam logic [Exponent_Size-1:0] EXP_MAX = Exponent_Size'(exp_all_ones(Exponent_Size));
    localparam logic [Exponent_Size-1:0] EXP_ONE = Exponent_Size'(1);

    state_t                   state, state_nxt;
    logic [Mantissa_Size:0]   m_r, m_nxt;
    logic [Exponent_Size-1:0] e_r, e_nxt, e_inc;
    logic                     tag_r, tag_nxt;
    logic                     zero_r, zero_nxt;
    logic                     ovf_r, ovf_nxt;
    logic                     unf_r, unf_nxt;
    logic [1:0]               grant;
    logic                     grant_idx;
    logic                     arb_enable;

    // Grants are suppressed while reset is asserted so no request slips in.
    assign arb_enable = (state == ST_IDLE) && rst_n;

    fpu_rr_arbiter2 u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (arb_enable),
        .req       (bus.req_valid),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            m_r    <= '0;
            e_r    <= '0;
            tag_r  <= 1'b0;
            zero_r <= 1'b0;
            ovf_r  <= 1'b0;
            unf_r  <= 1'b0;
        end else begin
            state  <= state_nxt;
            m_r    <= m_nxt;
            e_r    <= e_nxt;
            tag_r  <= tag_nxt;
            zero_r <= zero_nxt;
            ovf_r  <= ovf_nxt;
            unf_r  <= unf_nxt;
        end
    end

    // SHIFT checks run in strict priority; the all-ones and zero-exponent
    // checks keep the exponent arithmetic from ever wrapping.
    always_comb begin
        state_nxt = state;
        m_nxt     = m_r;
        e_nxt     = e_r;
        tag_nxt   = tag_r;
        zero_nxt  = zero_r;
        ovf_nxt   = ovf_r;
        unf_nxt   = unf_r;
        e_inc     = e_r + EXP_ONE;
        case (state)
            ST_IDLE: begin
                if (|grant) begin
                    tag_nxt   = grant_idx;
                    m_nxt     = (grant_idx == TAG_MUL) ? bus.req_mantissa1 : bus.req_mantissa0;
                    e_nxt     = (grant_idx == TAG_MUL) ? bus.req_exponent1 : bus.req_exponent0;
                    zero_nxt  = 1'b0;
                    ovf_nxt   = 1'b0;
                    unf_nxt   = 1'b0;
                    state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (e_r == EXP_MAX) begin
                    state_nxt = ST_DONE;
                end else if (m_r == '0) begin
                    zero_nxt  = 1'b1;
                    e_nxt     = '0;
                    state_nxt = ST_DONE;
                end else if (m_r[Mantissa_Size]) begin
                    m_nxt     = m_r >> 1;
                    e_nxt     = e_inc;
                    if (e_inc == EXP_MAX) begin
                        ovf_nxt = 1'b1;
                        m_nxt   = '0;
                    end
                    state_nxt = ST_DONE;
                end else if (m_r[Mantissa_Size-1]) begin
                    state_nxt = ST_DONE;
                end else if (e_r == '0) begin
                    unf_nxt   = 1'b1;
                    state_nxt = ST_DONE;
                end else begin
                    m_nxt = m_r << 1;
                    e_nxt = e_r - EXP_ONE;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign bus.req_ready     = grant;
    assign bus.out_valid     = (state == ST_DONE);
    assign bus.out_tag       = tag_r;
    assign bus.out_mantissa  = m_r[Mantissa_Size-1:0];
    assign bus.out_exponent  = e_r;
    assign bus.out_zero      = zero_r;
    assign bus.out_overflow  = ovf_r;
    assign bus.out_underflow = unf_r;
    assign bus.busy          = (state != ST_IDLE);

endmodule

// File: tb/tb_fpu_norm_sequencer.sv
// Self-checking bench for fpu_norm_sequencer: directed and random operations
// compared against a leading-one based reference model.
module tb_fpu_norm_sequencer;
    import fpu_pkg::*;

    logic clk;
    logic rst_n;
    int   vectors     = 0;
    int   miscompares = 0;

    fpu_norm_sequencer_if #(.Mantissa_Size(23), .Exponent_Size(8)) bus ();

    fpu_norm_sequencer #(.Mantissa_Size(23), .Exponent_Size(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [22:0] mant;
        logic [7:0]  exp;
        logic [2:0]  flags;
        int          lat;
    } ref_t;

    // Result from the position of the leading one: k = shifts to reach bit 22.
    function automatic ref_t ref_norm(input logic [23:0] m, input logic [7:0] e);
        ref_t r;
        int lead;
        int k;
        logic [23:0] t;
        r.mant  = m[22:0];
        r.exp   = e;
        r.flags = 3'b000;
        r.lat   = 2;
        lead    = -1;
        for (int i = 0; i < 24; i++) if (m[i]) lead = i;
        if (e != 8'hFF) begin
            if (lead < 0) begin
                r.mant  = '0;
                r.exp   = 8'h00;
                r.flags = 3'b100;
            end else if (lead == 23) begin
                if (e == 8'hFE) begin
                    r.mant  = '0;
                    r.exp   = 8'hFF;
                    r.flags = 3'b010;
                end else begin
                    t      = m >> 1;
                    r.mant = t[22:0];
                    r.exp  = e + 8'd1;
                end
            end else begin
                k = 22 - lead;
                if (k <= int'(e)) begin
                    t      = m << k;
                    r.mant = t[22:0];
                    r.exp  = 8'(int'(e) - k);
                    r.lat  = 2 + k;
                end else begin
                    t       = m << e;
                    r.mant  = t[22:0];
                    r.exp   = 8'h00;
                    r.flags = 3'b001;
                    r.lat   = 2 + int'(e);
                end
            end
        end
        return r;
    endfunction

    task automatic check_output(input string name, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, expv);
        end
    endtask

    task automatic check_result(input string name, input int tag, input ref_t r, input int cyc);
        check_output({name, " latency"}, cyc, r.lat);
        check_output({name, " valid"}, 32'(bus.out_valid), 32'd1);
        check_output({name, " tag"}, 32'(bus.out_tag), tag);
        check_output({name, " mantissa"}, 32'(bus.out_mantissa), 32'(r.mant));
        check_output({name, " exponent"}, 32'(bus.out_exponent), 32'(r.exp));
        check_output({name, " flags"}, 32'({bus.out_zero, bus.out_overflow, bus.out_underflow}), 32'(r.flags));
    endtask

    task automatic apply_stimulus(input int idx, input logic [23:0] m, input logic [7:0] e,
                                  input int stall, input string name);
        ref_t r;
        int n;
        int cyc;
        r = ref_norm(m, e);
        @(negedge clk);
        if (stall > 0) bus.out_ready = 1'b0;
        if (idx == 0) begin
            bus.req_mantissa0 = m;
            bus.req_exponent0 = e;
        end else begin
            bus.req_mantissa1 = m;
            bus.req_exponent1 = e;
        end
        bus.req_valid = 2'(1 << idx);
        #1;
        n = 0;
        while (bus.req_ready != 2'(1 << idx) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_output({name, " grant"}, 32'(bus.req_ready), 32'(1 << idx));
        check_output({name, " grant wait"}, n, 0);
        @(negedge clk);
        bus.req_valid = 2'b00;
        cyc = 1;
        while (!bus.out_valid && cyc < 64) begin
            @(negedge clk);
            cyc++;
        end
        check_result(name, idx, r, cyc);
        // The other requester knocks while the result is held back.
        for (int s = 0; s < stall; s++) begin
            bus.req_valid = 2'(1 << (1 - idx));
            @(negedge clk);
            #1;
            check_output({name, " stall ready"}, 32'(bus.req_ready), 32'd0);
            check_result({name, " stall"}, idx, r, r.lat);
        end
        bus.req_valid = 2'b00;
        bus.out_ready = 1'b1;
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst_n         = 1'b0;
        bus.req_valid = 2'b00;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        ref_t r0, r1;
        int   n, cyc, seen, idx;
        logic [23:0] m;
        logic [7:0]  e;

        rst_n             = 1'b0;
        bus.req_valid     = 2'b11;
        bus.req_mantissa0 = 24'h400000;
        bus.req_exponent0 = 8'd50;
        bus.req_mantissa1 = 24'h200000;
        bus.req_exponent1 = 8'd60;
        bus.out_ready     = 1'b1;
        repeat (3) @(negedge clk);
        check_output("reset req_ready", 32'(bus.req_ready), 32'd0);
        check_output("reset out_valid", 32'(bus.out_valid), 32'd0);
        check_output("reset busy", 32'(bus.busy), 32'd0);
        check_output("reset mantissa", 32'(bus.out_mantissa), 32'd0);
        check_output("reset exponent", 32'(bus.out_exponent), 32'd0);
        check_output("reset tag", 32'(bus.out_tag), 32'd0);
        check_output("reset flags", 32'({bus.out_zero, bus.out_overflow, bus.out_underflow}), 32'd0);
        rst_n         = 1'b1;
        bus.req_valid = 2'b00;

        $display("[TB] directed operations");
        apply_stimulus(TAG_MUL, 24'hC00000, 8'hFE, 0, "carry overflow");
        apply_stimulus(TAG_ADD, 24'h400000, 8'd130, 0, "normalized");
        apply_stimulus(TAG_ADD, 24'h800000, 8'd130, 0, "carry");
        apply_stimulus(TAG_MUL, 24'h000100, 8'd100, 0, "shift14");
        apply_stimulus(TAG_ADD, 24'h000100, 8'd5, 0, "underflow");
        apply_stimulus(TAG_MUL, 24'h000000, 8'd77, 0, "zero");
        apply_stimulus(TAG_ADD, 24'h123456, 8'hFF, 0, "inf");
        apply_stimulus(TAG_MUL, 24'hFFFFFF, 8'hFF, 0, "nan carry");
        apply_stimulus(TAG_ADD, 24'h000001, 8'd22, 0, "worst exact");
        apply_stimulus(TAG_MUL, 24'h000400, 8'd0, 0, "exp zero");
        apply_stimulus(TAG_MUL, 24'h010000, 8'd40, 5, "stalled");

        $display("[TB] random operations");
        for (int i = 0; i < 24; i++) begin
            idx = int'($urandom_range(0, 1));
            m   = 24'($urandom) >> $urandom_range(0, 24);
            case ($urandom_range(0, 3))
                0:       e = 8'($urandom_range(0, 12));
                1:       e = 8'($urandom_range(250, 255));
                default: e = 8'($urandom);
            endcase
            apply_stimulus(idx, m, e, 0, "random");
        end

        $display("[TB] arbitration with both requesters valid");
        reset_dut();
        r0 = ref_norm(24'h400000, 8'd10);
        r1 = ref_norm(24'h200000, 8'd20);
        @(negedge clk);
        bus.req_mantissa0 = 24'h400000;
        bus.req_exponent0 = 8'd10;
        bus.req_mantissa1 = 24'h200000;
        bus.req_exponent1 = 8'd20;
        bus.req_valid     = 2'b11;
        #1;
        for (int i = 0; i < 4; i++) begin
            n = 0;
            while (bus.req_ready == 2'b00 && n < 50) begin
                @(negedge clk);
                n++;
            end
            check_output("arb grant", 32'(bus.req_ready), 32'(1 << (i % 2)));
            @(negedge clk);
            cyc = 1;
            while (!bus.out_valid && cyc < 64) begin
                @(negedge clk);
                cyc++;
            end
            check_result("arb", i % 2, (i % 2 == 1) ? r1 : r0, cyc);
        end
        bus.req_valid = 2'b00;

        $display("[TB] reset during shifting");
        @(negedge clk);
        bus.req_mantissa0 = 24'h001000;
        bus.req_exponent0 = 8'd100;
        bus.req_valid     = 2'b01;
        #1;
        check_output("midreset grant", 32'(bus.req_ready), 32'd1);
        @(negedge clk);
        bus.req_valid = 2'b00;
        repeat (3) @(negedge clk);
        check_output("midreset busy before", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check_output("midreset out_valid", 32'(bus.out_valid), 32'd0);
        check_output("midreset busy", 32'(bus.busy), 32'd0);
        check_output("midreset flags", 32'({bus.out_zero, bus.out_overflow, bus.out_underflow}), 32'd0);
        rst_n = 1'b1;
        seen  = 0;
        repeat (15) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        check_output("midreset no result", seen, 0);
        apply_stimulus(TAG_MUL, 24'h001000, 8'd100, 0, "after reset");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
